rx_cmd_parser: RTL
==================

# rx_cmd_parser

Host-command deframer that sits directly downstream of the RX FIFO (FT245 → rx_fifo) and upstream of the controller state machine. It pops one command byte, plus a 2-byte big-endian payload for payload-carrying commands. It aborts on inter-byte timeout and presents a complete {cmd, payload} word through a valid/ready handshake. This removes all byte-level FIFO sequencing from the controller.

## Interface
- `LONG_CMD_A`, default 8'h05: command code that carries a 2-byte payload (set-register).
- `LONG_CMD_B`, default 8'h06: second command code that carries a 2-byte payload (AD9826 config r/w).
- `TIMEOUT_CYCLES`, default 1000000: maximum cycles spent waiting for a payload byte (10 ms at 100 MHz); 0 disables the timeout.
- `clk` in 1: system clock (100 MHz). One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `rx_rempty` in 1: RX FIFO empty flag; `rx_rdata` is valid when this is 0.
- `rx_rdata` in 8: RX FIFO head byte (first-word-fall-through).
- `rx_rinc` out 1: RX FIFO pop, one cycle per byte.
- `ft_busy` in 1: FT245 interface is mid-transfer; no pop is allowed while it is 1.
- `cmd_valid` out 1: a complete command is presented.
- `cmd_ready` in 1: the consumer accepts the command.
- `cmd` out 8: command byte.
- `payload` out 16: {msb, lsb}; 16'h0000 for short commands.
- `err_timeout` out 1: one-cycle pulse when a partial command is discarded.
- `busy` out 1: high in every state except IDLE.
- `cmd_count` out 8: accepted commands, wraps at 255→0.
- `timeout_count` out 8: timeouts, saturates at 255.

## Operation
- States: IDLE, SETTLE_CMD, WAIT_MSB, SETTLE_MSB, WAIT_LSB, SETTLE_LSB, PRESENT.
- Pop condition, evaluated in IDLE / WAIT_MSB / WAIT_LSB: `rx_rempty==0 && ft_busy==0`.
  - When the pop condition holds, `rx_rinc=1` combinationally in that cycle.
  - The byte is registered at the same edge.
- IDLE: on pop, latch `cmd` → SETTLE_CMD.
- SETTLE_CMD: one cycle, no pop; this allows the FIFO head/empty flag to update.
  - If `cmd` is LONG_CMD_A or LONG_CMD_B → WAIT_MSB.
  - Otherwise: `payload`=0 → PRESENT.
- WAIT_MSB: on pop, latch msb → SETTLE_MSB → WAIT_LSB.
- WAIT_LSB: on pop, latch lsb → SETTLE_LSB → PRESENT.
- PRESENT: `cmd_valid=1`.
  - `cmd` and `payload` are held stable until `cmd_ready=1`.
  - Handshake completes in any cycle where both are 1; increment `cmd_count` and go → IDLE.
- Timeout counter (width `$clog2(TIMEOUT_CYCLES+1)`):
  - Cleared on entry to WAIT_MSB and to WAIT_LSB.
  - Increments every cycle spent in a WAIT state without a pop.
  - When it reaches TIMEOUT_CYCLES: pulse `err_timeout`, increment `timeout_count` (saturating), discard cmd/msb, go → IDLE.
  - A pop in the expiry cycle wins over the timeout.
- `ft_busy=1` stalls pops in every state but does not stop the timeout counter.
- Unknown command codes are presented as short commands; validation belongs to the consumer.

## Timing
- Reset values: `rx_rinc`=0, `cmd_valid`=0, `cmd`=0, `payload`=0, `err_timeout`=0, `busy`=0, `cmd_count`=0, `timeout_count`=0, state IDLE, timeout counter 0.
- `rst` overrides everything, including mid-command; bytes already popped are lost, and `rx_rinc`=0 while `rst`=1.
- Latency, with byte available and `ft_busy=0` throughout, counting from the cmd-pop cycle c0:
  - Short command: `cmd_valid` high at c2.
  - Long command: msb pop at c2, lsb pop at c4, `cmd_valid` at c6.
- Pop rate: at most one pop every 2 cycles (SETTLE states).
- If `cmd_ready` is held 1: a short command occupies 3 cycles (c0..c2) and the next cmd pop is at c3.
- `rx_rinc` is never asserted while `rx_rempty=1`, while `ft_busy=1`, or in SETTLE/PRESENT states.
- `err_timeout` fires in the cycle the counter equals TIMEOUT_CYCLES; `busy` drops in the following cycle.
- `cmd_count` wraps 8'hFF→8'h00; `timeout_count` holds 8'hFF.

## Test plan
- Short command: push 8'h01 with `cmd_ready` tied 1 → `rx_rinc` pulses once at c0; `cmd_valid` at c2 with `cmd`=8'h01 and `payload`=16'h0000; `cmd_count`=1.
- Long command: push 8'h05, 8'h02, 8'hA5 → `cmd_valid` at c6 with `payload`=16'h02A5; exactly 3 `rx_rinc` pulses.
- Backpressure and busy:
  - Hold `cmd_ready`=0 for 20 cycles → `cmd`/`payload` stable and no pops during those cycles; release → accepted in one cycle.
  - With `ft_busy`=1 and data queued → no pop until `ft_busy` falls.
- Timeout, with TIMEOUT_CYCLES=16:
  - Push only 8'h06, 8'h11 → `err_timeout` pulse 16 cycles after entering WAIT_LSB; no `cmd_valid`; `timeout_count`=1.
  - The next byte 8'h01 then parses as a fresh short command.
- Expiry race: lsb arrives in exactly the expiry cycle → byte accepted, no `err_timeout`, command presented.
- Reset mid-payload: assert `rst` in SETTLE_MSB → all outputs 0 next cycle, state IDLE; the counters wrap (256 commands → `cmd_count`=0) and saturate as specified.

Source files
------------

// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser: host-command deframer between the RX FIFO and the controller.
// Pops one command byte and, for payload-carrying commands, a 2-byte
// big-endian payload. The finished {cmd, payload} word is presented over a
// valid/ready handshake. A partial command is dropped if a payload byte does
// not arrive within TIMEOUT_CYCLES.
//
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   rx_rempty       : RX FIFO empty flag (rx_rdata is valid when low)
//   rx_rdata[7:0]   : RX FIFO head byte (first-word-fall-through)
//   rx_rinc         : RX FIFO pop, combinational in the pop cycle
//   ft_busy         : FT245 transfer in progress, blocks pops
//   cmd_valid       : complete command presented
//   cmd_ready       : consumer accepts the command
//   cmd[7:0]        : command byte
//   payload[15:0]   : {msb, lsb}, zero for short commands
//   err_timeout     : one-cycle pulse when a partial command is discarded
//   busy            : parser is not idle
//   cmd_count[7:0]  : accepted commands, wrapping
//   timeout_count[7:0] : timeouts, saturating
module rx_cmd_parser #(
    parameter logic [7:0]  LONG_CMD_A     = 8'h05,
    parameter logic [7:0]  LONG_CMD_B     = 8'h06,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rempty,
    input  logic [7:0]  rx_rdata,
    output logic        rx_rinc,
    input  logic        ft_busy,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd,
    output logic [15:0] payload,
    output logic        err_timeout,
    output logic        busy,
    output logic [7:0]  cmd_count,
    output logic [7:0]  timeout_count
);

    // A zero TIMEOUT_CYCLES disables the timeout; keep the counter 1 bit wide then.
    localparam int unsigned   TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SETTLE_CMD = 3'd1,
        S_WAIT_MSB   = 3'd2,
        S_SETTLE_MSB = 3'd3,
        S_WAIT_LSB   = 3'd4,
        S_SETTLE_LSB = 3'd5,
        S_PRESENT    = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      msb_q, msb_d;
    logic [7:0]      lsb_q, lsb_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      cmd_count_q, cmd_count_d;
    logic [7:0]      timeout_count_q, timeout_count_d;
    logic            can_pop;
    logic            pop;
    logic            expire;

    // Reset gates the pop so no byte is consumed while rst is high.
    assign can_pop = !rx_rempty && !ft_busy && !rst;

    // Next-state, datapath capture and pop/timeout decode.
    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        msb_d           = msb_q;
        lsb_d           = lsb_q;
        tmo_d           = '0;
        cmd_count_d     = cmd_count_q;
        timeout_count_d = timeout_count_q;
        pop             = 1'b0;
        expire          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    cmd_d   = rx_rdata;
                    state_d = S_SETTLE_CMD;
                end
            end

            S_SETTLE_CMD: begin
                if ((cmd_q == LONG_CMD_A) || (cmd_q == LONG_CMD_B)) begin
                    state_d = S_WAIT_MSB;
                end else begin
                    msb_d   = 8'h00;
                    lsb_d   = 8'h00;
                    state_d = S_PRESENT;
                end
            end

            // A pop in the expiry cycle takes priority over the timeout.
            S_WAIT_MSB, S_WAIT_LSB: begin
                if (can_pop) begin
                    pop = 1'b1;
                    if (state_q == S_WAIT_MSB) begin
                        msb_d   = rx_rdata;
                        state_d = S_SETTLE_MSB;
                    end else begin
                        lsb_d   = rx_rdata;
                        state_d = S_SETTLE_LSB;
                    end
                end else if (TMO_EN && (tmo_q == TMO_LIMIT)) begin
                    expire          = 1'b1;
                    cmd_d           = 8'h00;
                    msb_d           = 8'h00;
                    lsb_d           = 8'h00;
                    timeout_count_d = (timeout_count_q == 8'hFF) ? 8'hFF
                                                                 : timeout_count_q + 8'd1;
                    state_d         = S_IDLE;
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_SETTLE_MSB: state_d = S_WAIT_LSB;

            S_SETTLE_LSB: state_d = S_PRESENT;

            S_PRESENT: begin
                if (cmd_ready) begin
                    cmd_count_d = cmd_count_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cmd_q           <= 8'h00;
            msb_q           <= 8'h00;
            lsb_q           <= 8'h00;
            tmo_q           <= '0;
            cmd_count_q     <= 8'h00;
            timeout_count_q <= 8'h00;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            msb_q           <= msb_d;
            lsb_q           <= lsb_d;
            tmo_q           <= tmo_d;
            cmd_count_q     <= cmd_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // FIFO pop and timeout pulse must land in the cycle of the decision.
    assign rx_rinc       = pop;
    assign err_timeout   = expire && !rst;
    assign cmd_valid     = (state_q == S_PRESENT);
    assign busy          = (state_q != S_IDLE);
    assign cmd           = cmd_q;
    assign payload       = {msb_q, lsb_q};
    assign cmd_count     = cmd_count_q;
    assign timeout_count = timeout_count_q;

endmodule
